// File: rtl/custom_fifo_pkg.sv
// Shared async-FIFO pointer helpers: Gray/binary conversion and default sizing.
// Latency: n/a (functions and constants only).
// Backpressure: n/a.
package custom_fifo_pkg;

  localparam int DEF_ADDRSIZE = 4;
  localparam int DEF_AF_LEVEL = 2;

  // Widest pointer the helpers cover; callers zero-extend and keep the low bits.
  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/custom_wptr_full_if.sv
// Write-side pointer/flag bundle between producer, FIFO memory and read domain.
// Latency: n/a (wires only).
// Backpressure: producer must treat fifo_full as the stop condition; wr_accept marks taken writes.
// Ports: master = producer/environment (drives wen, rptr_sync2_wrclk),
//        slave  = custom_wptr_full (drives flags, pointer, address, level).
interface custom_wptr_full_if
  import custom_fifo_pkg::*;
#(
  parameter int ADDRSIZE = DEF_ADDRSIZE
);
  logic                wen;
  logic [ADDRSIZE:0]   rptr_sync2_wrclk;
  logic                fifo_full;
  logic                fifo_almost_full;
  logic                wr_accept;
  logic [ADDRSIZE-1:0] wr_addr;
  logic [ADDRSIZE:0]   wptr_g;
  logic [ADDRSIZE:0]   wr_level;
  logic                fifo_overflow;

  modport master (
    output wen, rptr_sync2_wrclk,
    input  fifo_full, fifo_almost_full, wr_accept, wr_addr, wptr_g, wr_level, fifo_overflow
  );

  modport slave (
    input  wen, rptr_sync2_wrclk,
    output fifo_full, fifo_almost_full, wr_accept, wr_addr, wptr_g, wr_level, fifo_overflow
  );
endinterface

// File: rtl/custom_wptr_full_gray2bin.sv
// Gray-code to binary converter (module custom_gray2bin).
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: i_gray (WIDTH) Gray input, o_bin (WIDTH) binary output.
module custom_gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at and above its position.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end

endmodule

// File: rtl/custom_wptr_full.sv
// Async-FIFO write-side pointer, full/almost-full flags, occupancy and overflow tracking.
// Latency: accepted write or read-pointer change shows on flags/level/wptr_g after 1 wclk_i edge.
// Backpressure: wen while fifo_full is dropped (wr_accept=0) and sets sticky fifo_overflow.
// Ports: wclk_i clock, wrst_n_i async active-low reset, bus = custom_wptr_full_if.slave.
module custom_wptr_full
  import custom_fifo_pkg::*;
#(
  parameter int ADDRSIZE = DEF_ADDRSIZE,
  parameter int AF_LEVEL = DEF_AF_LEVEL
) (
  input  logic              wclk_i,
  input  logic              wrst_n_i,
  custom_wptr_full_if.slave bus
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AF_THRESH = PW'((1 << ADDRSIZE) - AF_LEVEL);

  logic [ADDRSIZE:0] r_wbin;
  logic [ADDRSIZE:0] r_wptr_g;
  logic [ADDRSIZE:0] r_level;
  logic              r_full;
  logic              r_almost_full;
  logic              r_overflow;

  logic              w_wr_accept;
  logic [ADDRSIZE:0] w_wbin_next;
  logic [ADDRSIZE:0] w_wgray_next;
  logic [ADDRSIZE:0] w_rbin_sync;
  logic [ADDRSIZE:0] w_level_next;
  logic [ADDRSIZE:0] w_rptr_full_cmp;
  logic              w_full_next;
  logic              w_almost_full_next;

  assign w_wr_accept  = bus.wen & ~r_full;
  assign w_wbin_next  = r_wbin + PW'(w_wr_accept);
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  // In Gray code the write pointer is exactly one lap ahead of the read
  // pointer when the two MSBs differ and all lower bits match.
  assign w_rptr_full_cmp = {~bus.rptr_sync2_wrclk[ADDRSIZE:ADDRSIZE-1],
                            bus.rptr_sync2_wrclk[ADDRSIZE-2:0]};
  assign w_full_next     = (w_wgray_next == w_rptr_full_cmp);

  custom_gray2bin #(.WIDTH(PW)) u_rptr_g2b (
    .i_gray (bus.rptr_sync2_wrclk),
    .o_bin  (w_rbin_sync)
  );

  // Modular subtraction handles pointer wrap; result spans 0..2**ADDRSIZE.
  assign w_level_next       = w_wbin_next - w_rbin_sync;
  assign w_almost_full_next = (w_level_next >= AF_THRESH) | w_full_next;

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      r_wbin        <= '0;
      r_wptr_g      <= '0;
      r_level       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wbin        <= w_wbin_next;
      r_wptr_g      <= w_wgray_next;
      r_level       <= w_level_next;
      r_full        <= w_full_next;
      r_almost_full <= w_almost_full_next;
      r_overflow    <= r_overflow | (bus.wen & r_full);
    end
  end

  assign bus.wr_accept        = w_wr_accept;
  assign bus.wr_addr          = r_wbin[ADDRSIZE-1:0];
  assign bus.wptr_g           = r_wptr_g;
  assign bus.wr_level         = r_level;
  assign bus.fifo_full        = r_full;
  assign bus.fifo_almost_full = r_almost_full;
  assign bus.fifo_overflow    = r_overflow;

endmodule

// File: tb/tb_custom_wptr_full.sv
// Directed table-driven bench for custom_wptr_full at ADDRSIZE=2, AF_LEVEL=1 (depth 4).
// Latency: checks combinational outputs before each edge and registered outputs 1 ns after.
// Backpressure: exercises write-while-full drop and sticky overflow.
module tb_custom_wptr_full;

  localparam int AS = 2;

  logic clk;
  logic rst_n;

  custom_wptr_full_if #(.ADDRSIZE(AS)) u_if ();

  custom_wptr_full #(.ADDRSIZE(AS), .AF_LEVEL(1)) dut (
    .wclk_i   (clk),
    .wrst_n_i (rst_n),
    .bus      (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wen;
    logic [2:0] rptr;
    logic       e_acc;     // wr_accept before the edge
    logic [1:0] e_addr0;   // wr_addr before the edge
    logic [2:0] e_wptr;    // after the edge
    logic [1:0] e_addr;
    logic [2:0] e_lvl;
    logic       e_full;
    logic       e_af;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[17];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " wptr_g"},  32'(u_if.wptr_g), 0);
    check({tag, " wr_addr"}, 32'(u_if.wr_addr), 0);
    check({tag, " wr_level"}, 32'(u_if.wr_level), 0);
    check({tag, " full"},    32'(u_if.fifo_full), 0);
    check({tag, " afull"},   32'(u_if.fifo_almost_full), 0);
    check({tag, " ovf"},     32'(u_if.fifo_overflow), 0);
  endtask

  task automatic apply(input int i);
    string t;
    t = $sformatf("v%0d", i);
    u_if.wen              = vecs[i].wen;
    u_if.rptr_sync2_wrclk = vecs[i].rptr;
    #1;
    check({t, " wr_accept"}, 32'(u_if.wr_accept), 32'(vecs[i].e_acc));
    check({t, " wr_addr_pre"}, 32'(u_if.wr_addr), 32'(vecs[i].e_addr0));
    @(posedge clk);
    #1;
    check({t, " wptr_g"},   32'(u_if.wptr_g), 32'(vecs[i].e_wptr));
    check({t, " wr_addr"},  32'(u_if.wr_addr), 32'(vecs[i].e_addr));
    check({t, " wr_level"}, 32'(u_if.wr_level), 32'(vecs[i].e_lvl));
    check({t, " full"},     32'(u_if.fifo_full), 32'(vecs[i].e_full));
    check({t, " afull"},    32'(u_if.fifo_almost_full), 32'(vecs[i].e_af));
    check({t, " ovf"},      32'(u_if.fifo_overflow), 32'(vecs[i].e_ovf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             wen rptr    acc addr0 wptr    addr   lvl    full af  ovf
    // Fill from empty, overflow, then drain by one (rptr fixed at 0 first).
    vecs[0]  = '{1, 3'b000, 1, 2'd0, 3'b001, 2'd1, 3'd1, 0, 0, 0};
    vecs[1]  = '{1, 3'b000, 1, 2'd1, 3'b011, 2'd2, 3'd2, 0, 0, 0};
    vecs[2]  = '{1, 3'b000, 1, 2'd2, 3'b010, 2'd3, 3'd3, 0, 1, 0};
    vecs[3]  = '{1, 3'b000, 1, 2'd3, 3'b110, 2'd0, 3'd4, 1, 1, 0};
    vecs[4]  = '{1, 3'b000, 0, 2'd0, 3'b110, 2'd0, 3'd4, 1, 1, 1};
    vecs[5]  = '{0, 3'b000, 0, 2'd0, 3'b110, 2'd0, 3'd4, 1, 1, 1};
    vecs[6]  = '{0, 3'b001, 0, 2'd0, 3'b110, 2'd0, 3'd3, 0, 1, 1};
    // Read to level 2, then simultaneous write + read keeps level 2.
    vecs[7]  = '{0, 3'b011, 0, 2'd0, 3'b110, 2'd0, 3'd2, 0, 0, 1};
    vecs[8]  = '{1, 3'b010, 1, 2'd0, 3'b111, 2'd1, 3'd2, 0, 0, 1};
    // After reset: 8 writes with read pointer trailing by 2, full lap.
    vecs[9]  = '{1, 3'b000, 1, 2'd0, 3'b001, 2'd1, 3'd1, 0, 0, 0};
    vecs[10] = '{1, 3'b000, 1, 2'd1, 3'b011, 2'd2, 3'd2, 0, 0, 0};
    vecs[11] = '{1, 3'b001, 1, 2'd2, 3'b010, 2'd3, 3'd2, 0, 0, 0};
    vecs[12] = '{1, 3'b011, 1, 2'd3, 3'b110, 2'd0, 3'd2, 0, 0, 0};
    vecs[13] = '{1, 3'b010, 1, 2'd0, 3'b111, 2'd1, 3'd2, 0, 0, 0};
    vecs[14] = '{1, 3'b110, 1, 2'd1, 3'b101, 2'd2, 3'd2, 0, 0, 0};
    vecs[15] = '{1, 3'b111, 1, 2'd2, 3'b100, 2'd3, 3'd2, 0, 0, 0};
    vecs[16] = '{1, 3'b101, 1, 2'd3, 3'b000, 2'd0, 3'd2, 0, 0, 0};

    u_if.wen              = 1'b0;
    u_if.rptr_sync2_wrclk = '0;
    rst_n                 = 1'b0;
    #1;
    check_reset_vals("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i <= 8; i++) apply(i);

    // Async reset in the middle of a cycle with non-zero state.
    @(posedge clk);
    #2;
    u_if.wen = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_vals("midrst");
    check("midrst wr_accept", 32'(u_if.wr_accept), 0);
    @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    @(negedge clk);
    rst_n                 = 1'b1;
    u_if.rptr_sync2_wrclk = '0;

    for (int i = 9; i <= 16; i++) apply(i);

    // Full can only clear through the read pointer: idle cycles keep it set.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i <= 3; i++) apply(i);
    u_if.wen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle full", 32'(u_if.fifo_full), 1);
    check("idle ovf", 32'(u_if.fifo_overflow), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
